// File: rtl/hash_job_scheduler_pkg.sv
// hash_sched_pkg: shared state encoding and datapath widths for the hash job scheduler
package hash_sched_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  localparam int BYTE_W = 8;
  localparam int HDR_W = BYTE_W * 12;
  localparam int NONCE_W = 32;
  localparam int TGT_W = 8;
endpackage

// File: rtl/hash_job_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or after ptr
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx
);
  logic found;
  // scan from ptr with wrap-around, first requester wins
  always_comb begin
    grant = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        grant[(int'(ptr) + k) % NUM_REQ] = 1'b1;
        idx = IW'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end
endmodule

// File: rtl/hash_job_scheduler.sv
// hash_job_scheduler: round-robin job loader and budgeted search supervisor for one mining datapath; SCHED_STATS_EN adds found/timeout counters
module hash_job_scheduler
  import hash_sched_pkg::*;
#(
  parameter int BYTE = BYTE_W,
  parameter int NUM_REQ = 2,
  parameter int LOAD_CYCLES = 2,
  parameter int MAX_CYCLES = 4096,
  localparam int IW = $clog2(NUM_REQ),
  localparam int HW = BYTE * 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*HW-1:0]   req_data,
  input  logic [NUM_REQ*TGT_W-1:0] req_target,
  output logic                    sys_reset,
  output logic [HW-1:0]           sys_data_in,
  output logic [TGT_W-1:0]        sys_target,
  input  logic                    sys_finished,
  input  logic [NONCE_W-1:0]      sys_nonce,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [IW-1:0]           res_id,
  output logic                    res_found,
  output logic [NONCE_W-1:0]      res_nonce,
  output logic                    busy
`ifdef SCHED_STATS_EN
  ,
  output logic [15:0]             stat_found,
  output logic [15:0]             stat_timeout
`endif
);
  localparam int CW = $clog2(MAX_CYCLES);
  localparam int LW = LOAD_CYCLES > 1 ? $clog2(LOAD_CYCLES) : 1;
  state_t state, nstate;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0] gidx, rr_ptr;
  logic [CW-1:0] cnt;
  logic [LW-1:0] lcnt;
  logic timeout, load_done;
  assign timeout = cnt == CW'(MAX_CYCLES - 1);
  assign load_done = lcnt == LW'(LOAD_CYCLES - 1);
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req(req_valid),
    .ptr(rr_ptr),
    .grant(grant),
    .idx(gidx)
  );
  // next state and state-decoded outputs; grants are suppressed while reset is asserted
  always_comb begin
    nstate = state == IDLE ? (|req_valid ? LOAD : IDLE) :
             state == LOAD ? (load_done ? RUN : LOAD) :
             state == RUN  ? (sys_finished || timeout ? DONE : RUN) :
                             (res_ready ? IDLE : DONE);
    req_ready = (reset && state == IDLE) ? grant : '0;
    sys_reset = state == RUN;
    res_valid = state == DONE;
    busy = state != IDLE;
  end
  // state, job latch, load/run counters and result capture
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      cnt <= '0;
      lcnt <= '0;
      sys_data_in <= '0;
      sys_target <= '0;
      res_id <= '0;
      res_found <= 1'b0;
      res_nonce <= '0;
    end else begin
      state <= nstate;
      if (state == IDLE && |req_valid) begin
        sys_data_in <= req_data[int'(gidx)*HW +: HW];
        sys_target <= req_target[int'(gidx)*TGT_W +: TGT_W];
        res_id <= gidx;
        cnt <= '0;
        lcnt <= '0;
      end
      if (state == LOAD) lcnt <= lcnt + 1'b1;
      if (state == RUN) begin
        if (sys_finished) begin
          res_found <= 1'b1;
          res_nonce <= sys_nonce;
        end else if (timeout) begin
          res_found <= 1'b0;
          res_nonce <= '0;
        end else cnt <= cnt + 1'b1;
      end
      if (state == DONE && res_ready) rr_ptr <= res_id == IW'(NUM_REQ - 1) ? '0 : res_id + 1'b1;
    end
  end
`ifdef SCHED_STATS_EN
  // saturating result counters, one step per accepted result
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_found <= '0;
      stat_timeout <= '0;
    end else if (state == DONE && res_ready) begin
      if (res_found && ~&stat_found) stat_found <= stat_found + 1'b1;
      if (!res_found && ~&stat_timeout) stat_timeout <= stat_timeout + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_hash_job_scheduler.sv
// tb_hash_job_scheduler: vector table plus scoreboard for hash_job_scheduler (NUM_REQ=2, LOAD_CYCLES=2, MAX_CYCLES=16)
module tb_hash_job_scheduler;
  localparam int LOADC = 2;
  localparam int MAXC = 16;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] req_valid, req_ready;
  logic [191:0] req_data;
  logic [15:0] req_target;
  logic sys_reset, sys_finished, res_valid, res_ready, res_found, busy;
  logic [95:0] sys_data_in;
  logic [7:0] sys_target;
  logic [31:0] sys_nonce, res_nonce;
  logic [0:0] res_id;
`ifdef SCHED_STATS_EN
  logic [15:0] stat_found, stat_timeout;
`endif
  int errors = 0;
  int checks = 0;
  int exp_f = 0;
  int exp_t = 0;
  logic [95:0] hdr [2];
  logic [7:0] tgt [2];
  typedef struct {
    logic [1:0] valid;
    int fin;
    logic [31:0] nonce;
    int bp;
    logic [0:0] exp_id;
    logic exp_found;
    logic [31:0] exp_nonce;
  } vec_t;
  typedef struct {
    logic [0:0] id;
    logic found;
    logic [31:0] nonce;
  } res_t;
  vec_t vecs [8];
  res_t sb [$];

  always #5 clk = ~clk;

  hash_job_scheduler #(.NUM_REQ(2), .LOAD_CYCLES(LOADC), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_target(req_target),
    .sys_reset(sys_reset), .sys_data_in(sys_data_in), .sys_target(sys_target),
    .sys_finished(sys_finished), .sys_nonce(sys_nonce),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_found(res_found),
    .res_nonce(res_nonce), .busy(busy)
`ifdef SCHED_STATS_EN
    , .stat_found(stat_found), .stat_timeout(stat_timeout)
`endif
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic new_headers(input bit fixed);
    hdr[0] = {$urandom, $urandom, $urandom};
    hdr[1] = {$urandom, $urandom, $urandom};
    tgt[0] = 8'($urandom);
    tgt[1] = 8'($urandom);
    if (fixed) begin
      hdr[0] = 96'h0123_4567_89AB_CDEF_0123_45AB;
      tgt[0] = 8'h10;
    end
    req_data = {hdr[1], hdr[0]};
    req_target = {tgt[1], tgt[0]};
  endtask

  task automatic run_vec(input vec_t v, input bit fixed);
    int k, lat, r;
    res_t e;
    new_headers(fixed);
    req_valid = v.valid;
    res_ready = 1'b0;
    sys_finished = 1'b0;
    #1;
    k = 0;
    while (!(|(req_valid & req_ready)) && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (k == 10) begin
      chk("grant_timeout", 1, 0);
      return;
    end
    chk("grant", req_ready, 2'b01 << v.exp_id);
    sb.push_back('{v.exp_id, v.exp_found, v.exp_nonce});
    @(negedge clk);
    req_valid = 2'b00;
    chk("sys_data_in", sys_data_in, hdr[v.exp_id]);
    chk("sys_target", sys_target, tgt[v.exp_id]);
    chk("load_sys_reset", sys_reset, 0);
    lat = 1;
    while (!sys_reset && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("load_latency", lat, 1 + LOADC);
    r = 0;
    while (sys_reset && r < 40) begin
      r++;
      sys_finished = (r == v.fin);
      sys_nonce = (r == v.fin) ? v.nonce : $urandom;
      @(negedge clk);
    end
    sys_finished = 1'b0;
    chk("run_cycles", r, v.fin != 0 ? v.fin : MAXC);
    chk("done_valid", res_valid, 1);
    chk("done_sys_reset", sys_reset, 0);
    req_valid = 2'b11;
    for (int i = 0; i < v.bp; i++) begin
      chk("bp_valid", res_valid, 1);
      chk("bp_ready", req_ready, 0);
      chk("bp_fields", {res_id, res_found, res_nonce}, {v.exp_id, v.exp_found, v.exp_nonce});
      @(negedge clk);
    end
    req_valid = 2'b00;
    res_ready = 1'b1;
    if (sb.size() == 0) chk("sb_empty", 1, 0);
    else begin
      e = sb.pop_front();
      chk("res_id", res_id, e.id);
      chk("res_found", res_found, e.found);
      chk("res_nonce", res_nonce, e.nonce);
    end
    if (v.exp_found) exp_f++;
    else exp_t++;
    @(negedge clk);
    res_ready = 1'b0;
    chk("after_accept_valid", res_valid, 0);
    chk("after_accept_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'b11, 5,  32'h0000_002A, 0, 1'b0, 1'b1, 32'h0000_002A};
    vecs[1] = '{2'b11, 0,  32'h1111_1111, 5, 1'b1, 1'b0, 32'h0};
    vecs[2] = '{2'b10, 3,  32'hDEAD_BEEF, 0, 1'b1, 1'b1, 32'hDEAD_BEEF};
    vecs[3] = '{2'b10, 16, 32'h0000_1234, 0, 1'b1, 1'b1, 32'h0000_1234};
    vecs[4] = '{2'b01, 0,  32'h5555_5555, 0, 1'b0, 1'b0, 32'h0};
    vecs[5] = '{2'b01, 1,  32'hFFFF_FFFF, 2, 1'b0, 1'b1, 32'hFFFF_FFFF};
    vecs[6] = '{2'b11, 0,  32'h7777_7777, 0, 1'b1, 1'b0, 32'h0};
    vecs[7] = '{2'b11, 2,  32'h0000_0077, 0, 1'b0, 1'b1, 32'h0000_0077};
    reset = 1'b0;
    req_valid = 2'b11;
    res_ready = 1'b0;
    sys_finished = 1'b0;
    sys_nonce = '0;
    new_headers(1'b0);
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_sys_reset", sys_reset, 0);
    chk("rst_outputs", {sys_data_in, sys_target, res_valid, res_id, res_found, res_nonce, busy}, 0);
    reset = 1'b1;
    for (int i = 0; i < 7; i++) run_vec(vecs[i], i == 0);
`ifdef SCHED_STATS_EN
    chk("stat_found", stat_found, exp_f);
    chk("stat_timeout", stat_timeout, exp_t);
`endif
    new_headers(1'b0);
    req_valid = 2'b10;
    #1;
    for (int k = 0; k < 10 && !sys_reset; k++) begin
      @(negedge clk);
      req_valid = 2'b00;
    end
    repeat (3) @(negedge clk);
    chk("mid_run_active", sys_reset, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_sys_reset", sys_reset, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_busy", busy, 0);
`ifdef SCHED_STATS_EN
    chk("mid_rst_stats", {stat_found, stat_timeout}, 0);
`endif
    exp_f = 0;
    exp_t = 0;
    reset = 1'b1;
    run_vec(vecs[7], 1'b0);
`ifdef SCHED_STATS_EN
    chk("stat_found_after_rst", stat_found, exp_f);
    chk("stat_timeout_after_rst", stat_timeout, exp_t);
`endif
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
